// File: rtl/spi_bitmap_writer_if.sv
// Byte stream from the SPI slave receiver and write port toward the bitmap RAM.
// Handshake: DataValid_i is a one-cycle valid pulse with no ready/backpressure; Data_i and DC_i are meaningful only while it is high.
interface spi_bitmap_writer_if #(
  parameter int ADDRESS_WIDTH = 11
);
  logic                     TransmissionStart_i;
  logic                     DataValid_i;
  logic [7:0]               Data_i;
  logic                     DC_i;
  logic                     WriteEnable_o;
  logic [ADDRESS_WIDTH-1:0] WriteAddress_o;
  logic [7:0]               WriteData_o;
  logic                     Busy_o;
  logic                     Error_o;
  logic [2:0]               state_dbg;

  modport master (
    output TransmissionStart_i, DataValid_i, Data_i, DC_i,
    input  WriteEnable_o, WriteAddress_o, WriteData_o, Busy_o, Error_o, state_dbg
  );

  modport slave (
    input  TransmissionStart_i, DataValid_i, Data_i, DC_i,
    output WriteEnable_o, WriteAddress_o, WriteData_o, Busy_o, Error_o, state_dbg
  );
endinterface

// File: rtl/spi_bitmap_writer.sv
// Decodes SPI data/command bytes into bitmap RAM writes: pixel data at an
// auto-incrementing pointer, plus SET_ADDR, FILL and HOME commands.
module spi_bitmap_writer #(
  parameter int ADDRESS_WIDTH = 11,
  parameter int MEMORY_DEPTH  = 1536
) (
  input logic              Clock,
  input logic              Reset,
  spi_bitmap_writer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR_HI  = 3'd1,
    S_ADDR_LO  = 3'd2,
    S_FILL_VAL = 3'd3,
    S_FILLING  = 3'd4
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEMORY_DEPTH - 1);
  localparam logic [15:0]              DEPTH16   = 16'(MEMORY_DEPTH);

  state_t                   state, state_nx, dec_state;
  logic [ADDRESS_WIDTH-1:0] ptr, ptr_nx;
  logic [7:0]               addr_hi, addr_hi_nx;
  logic [7:0]               fill_val, fill_val_nx;
  logic [ADDRESS_WIDTH-1:0] fill_cnt, fill_cnt_nx;
  logic                     we_q, we_nx;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_nx;
  logic [7:0]               wdata_q, wdata_nx;
  logic                     busy_q, busy_nx;
  logic                     err_q, err_nx;
  logic [15:0]              set_value;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= S_IDLE;
      ptr      <= '0;
      addr_hi  <= '0;
      fill_val <= '0;
      fill_cnt <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      addr_hi  <= addr_hi_nx;
      fill_val <= fill_val_nx;
      fill_cnt <= fill_cnt_nx;
      we_q     <= we_nx;
      waddr_q  <= waddr_nx;
      wdata_q  <= wdata_nx;
      busy_q   <= busy_nx;
      err_q    <= err_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    addr_hi_nx  = addr_hi;
    fill_val_nx = fill_val;
    fill_cnt_nx = fill_cnt;
    we_nx       = 1'b0;
    waddr_nx    = waddr_q;
    wdata_nx    = wdata_q;
    busy_nx     = 1'b0;
    err_nx      = err_q;
    set_value   = {addr_hi, bus.Data_i};

    // A CS falling edge cancels any half-received parameter sequence before
    // the byte of the same cycle is decoded.
    dec_state = state;
    if (bus.TransmissionStart_i &&
        (state == S_ADDR_HI || state == S_ADDR_LO || state == S_FILL_VAL)) begin
      dec_state = S_IDLE;
    end
    state_nx = dec_state;

    if (dec_state == S_FILLING) begin
      we_nx    = 1'b1;
      busy_nx  = 1'b1;
      waddr_nx = fill_cnt;
      wdata_nx = fill_val;
      if (fill_cnt == LAST_ADDR) begin
        state_nx    = S_IDLE;
        ptr_nx      = '0;
        fill_cnt_nx = '0;
      end else begin
        fill_cnt_nx = fill_cnt + 1'b1;
      end
      if (bus.DataValid_i) err_nx = 1'b1;
    end else if (bus.DataValid_i) begin
      if (bus.DC_i) begin
        we_nx    = 1'b1;
        waddr_nx = ptr;
        wdata_nx = bus.Data_i;
        ptr_nx   = (ptr == LAST_ADDR) ? '0 : ptr + 1'b1;
        state_nx = S_IDLE;
      end else begin
        case (dec_state)
          S_IDLE: begin
            case (bus.Data_i)
              8'h01:   state_nx = S_ADDR_HI;
              8'h02:   state_nx = S_FILL_VAL;
              8'h03:   ptr_nx   = '0;
              default: state_nx = S_IDLE;
            endcase
          end
          S_ADDR_HI: begin
            addr_hi_nx = bus.Data_i;
            state_nx   = S_ADDR_LO;
          end
          S_ADDR_LO: begin
            if (set_value < DEPTH16) begin
              ptr_nx = set_value[ADDRESS_WIDTH-1:0];
            end else begin
              ptr_nx = '0;
              err_nx = 1'b1;
            end
            state_nx = S_IDLE;
          end
          S_FILL_VAL: begin
            // Address 0 goes out right away; the counter then walks 1..LAST.
            fill_val_nx = bus.Data_i;
            we_nx       = 1'b1;
            busy_nx     = 1'b1;
            waddr_nx    = '0;
            wdata_nx    = bus.Data_i;
            fill_cnt_nx = ADDRESS_WIDTH'(1);
            state_nx    = S_FILLING;
          end
          default: state_nx = S_IDLE;
        endcase
      end
    end
  end

  assign bus.WriteEnable_o  = we_q;
  assign bus.WriteAddress_o = waddr_q;
  assign bus.WriteData_o    = wdata_q;
  assign bus.Busy_o         = busy_q;
  assign bus.Error_o        = err_q;
  assign bus.state_dbg      = state;

endmodule
